// File: rtl/ex_mem.sv
// EX->MEM pipeline register of the MIPS32 core. It also holds the MADD/MSUB partial product
// and cycle count while EX is stalled, and feeds them back to EX.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [ALUOP_W-1:0]  mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_reg2,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);

  logic [ADDR_W-1:0]   wd_q,    wd_d;
  logic                wreg_q,  wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q,    hi_d;
  logic [DATA_W-1:0]   lo_q,    lo_d;
  logic                whilo_q, whilo_d;
  logic [ALUOP_W-1:0]  aluop_q, aluop_d;
  logic [DATA_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   reg2_q,  reg2_d;
  logic [2*DATA_W-1:0] hilo_q,  hilo_d;
  logic [1:0]          cnt_q,   cnt_d;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // The illegal stall[3]=0/stall[4]=1 combination falls into the advance branch.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    aluop_d = aluop_q;
    addr_d  = addr_q;
    reg2_d  = reg2_q;
    hilo_d  = hilo_i;
    cnt_d   = cnt_i;
    if (!stall[3]) begin
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
      aluop_d = ex_aluop;
      addr_d  = ex_mem_addr;
      reg2_d  = ex_reg2;
      hilo_d  = '0;
      cnt_d   = '0;
    end else if (!stall[4]) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      aluop_d = '0;
      addr_d  = '0;
      reg2_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      aluop_q <= '0;
      addr_q  <= '0;
      reg2_q  <= '0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      aluop_q <= aluop_d;
      addr_q  <= addr_d;
      reg2_q  <= reg2_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd       = wd_q;
  assign mem_wreg     = wreg_q;
  assign mem_wdata    = wdata_q;
  assign mem_hi       = hi_q;
  assign mem_lo       = lo_q;
  assign mem_whilo    = whilo_q;
  assign mem_aluop    = aluop_q;
  assign mem_mem_addr = addr_q;
  assign mem_reg2     = reg2_q;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus randomized traffic against a
// transaction-level model of the EX->MEM register and MADD feedback state.
module tb_ex_mem;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0;
  logic        ex_whilo = 1'b0;
  logic [7:0]  ex_aluop = '0;
  logic [31:0] ex_mem_addr = '0, ex_reg2 = '0;
  logic [63:0] hilo_i = '0;
  logic [1:0]  cnt_i = '0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_t        exp_mem;
  logic [63:0] exp_hilo;
  logic [1:0]  exp_cnt;

  ex_mem #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // ctrl never issues EX running while MEM is stalled
  always @(posedge clk)
    if (!rst) assert (!(!stall[3] && stall[4])) else $error("illegal stall vector %b", stall);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wd"},    64'(mem_wd),       64'(exp_mem.wd));
    check({tag, ".wreg"},  64'(mem_wreg),     64'(exp_mem.wreg));
    check({tag, ".wdata"}, 64'(mem_wdata),    64'(exp_mem.wdata));
    check({tag, ".hi"},    64'(mem_hi),       64'(exp_mem.hi));
    check({tag, ".lo"},    64'(mem_lo),       64'(exp_mem.lo));
    check({tag, ".whilo"}, 64'(mem_whilo),    64'(exp_mem.whilo));
    check({tag, ".aluop"}, 64'(mem_aluop),    64'(exp_mem.aluop));
    check({tag, ".addr"},  64'(mem_mem_addr), 64'(exp_mem.addr));
    check({tag, ".reg2"},  64'(mem_reg2),     64'(exp_mem.reg2));
    check({tag, ".hilo"},  hilo_o,            exp_hilo);
    check({tag, ".cnt"},   64'(cnt_o),        64'(exp_cnt));
  endtask

  function automatic mem_t ex_bundle();
    return '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi, lo: ex_lo,
             whilo: ex_whilo, aluop: ex_aluop, addr: ex_mem_addr, reg2: ex_reg2};
  endfunction

  function automatic void model_reset();
    exp_mem  = '0;
    exp_hilo = '0;
    exp_cnt  = '0;
  endfunction

  // Model of one edge: EX moving on launches its instruction and restarts the MADD count;
  // EX stalled keeps the feedback state, with MEM either fed a bubble or frozen.
  function automatic void model_edge();
    if (!stall[3]) begin
      exp_mem  = ex_bundle();
      exp_hilo = '0;
      exp_cnt  = '0;
    end else begin
      if (!stall[4]) exp_mem = '0;
      exp_hilo = hilo_i;
      exp_cnt  = cnt_i;
    end
  endfunction

  task automatic edge_check(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_ex();
    ex_wd       = 5'($urandom);
    ex_wreg     = 1'($urandom);
    ex_wdata    = $urandom;
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_whilo    = 1'($urandom);
    ex_aluop    = 8'($urandom);
    ex_mem_addr = $urandom;
    ex_reg2     = $urandom;
    hilo_i      = {$urandom, $urandom};
    cnt_i       = 2'($urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("rst_init");

    // Async reset between edges with every input nonzero
    @(negedge clk);
    rst = 1'b0;
    rand_ex();
    ex_wreg = 1'b1; ex_whilo = 1'b1; ex_wd = 5'd17; ex_aluop = 8'h23; ex_wdata = 32'h1;
    cnt_i = 2'b01; hilo_i = 64'h1; stall = 6'b000000;
    edge_check("pre_rst");
    @(negedge clk);
    stall = 6'b001111;
    edge_check("pre_rst_bubble_feedback");
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("rst_async");
    @(posedge clk); #1 check_all("rst_held");

    // Pass-through
    @(negedge clk);
    rst = 1'b0; stall = '0;
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h0000_1234;
    edge_check("pass");
    check("pass.wdata_const", 64'(mem_wdata), 64'h1234);

    // Bubble while EX stalled
    @(negedge clk);
    stall = 6'b001111; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
    hilo_i = 64'h1_0000_0002; cnt_i = 2'b01;
    edge_check("bubble");
    check("bubble.hilo_const", hilo_o, 64'h1_0000_0002);

    // Full hold
    @(negedge clk);
    stall = '0; ex_wdata = 32'hA5A5_A5A5;
    edge_check("preload");
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_ex();
      stall = 6'b011111;
      edge_check("hold");
      check("hold.wdata_const", 64'(mem_wdata), 64'hA5A5_A5A5);
    end

    // MADD loop
    @(negedge clk);
    stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h0000_0002_0000_0000;
    edge_check("madd_c1");
    check("madd_c1.cnt_const", 64'(cnt_o), 64'd1);
    @(negedge clk);
    stall = '0; ex_whilo = 1'b1; cnt_i = 2'b10; hilo_i = 64'hFFFF;
    edge_check("madd_c2");
    check("madd_c2.cnt_const", 64'(cnt_o), 64'd0);

    // Reset mid-MADD
    @(negedge clk);
    stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h0000_0002_0000_0000;
    edge_check("madd2_c1");
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("madd_rst");
    @(negedge clk);
    rst = 1'b0; stall = '0; rand_ex();
    edge_check("after_madd_rst");

    // Randomized traffic with occasional async reset
    for (int unsigned i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = 1'b0;
      rand_ex();
      case ($urandom_range(0, 2))
        0: stall = {1'($urandom), 2'b00, 3'($urandom)};
        1: stall = {1'($urandom), 2'b01, 3'($urandom)};
        default: stall = {1'($urandom), 2'b11, 3'($urandom)};
      endcase
      edge_check("rand");
      if ($urandom_range(0, 40) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("rand_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
